pulse_generator: RTL and testbench
==================================

// Module: pulse_generator
// PURPOSE
//   Produces a burst of clean, registered pulses with programmable width, gap
//   and pulse count on one output line. It is the transmit-side counterpart of
//   our strobe edge detectors: every pulse it emits is a guaranteed
//   active/idle transition pair that a downstream edge detector can count.
//   It is used to drive test strobes, triggers and handshake lines between blocks.
// PARAMETERS
//   POLARITY  "HIGH"  active level of o_pulse: "HIGH" = idle 0, pulse 1; "LOW" = idle 1, pulse 0
//   CNT_W     16      width of the i_width / i_gap fields and their internal counters
//   NUM_W     8       width of the i_count field and the pulse counter
// PORTS
//   i_clk      in   1      clock; all logic on posedge
//   i_rst_n    in   1      reset, asynchronous assert, active-low
//   i_ena      in   1      clock enable; when low, state, counters and outputs hold
//   i_start    in   1      request a burst; sampled only in IDLE with i_ena=1
//   i_abort    in   1      terminate a burst; sampled whenever i_ena=1
//   i_width    in   CNT_W  active-phase length in cycles; 0 is treated as 1
//   i_gap      in   CNT_W  idle-phase length between pulses in cycles; 0 is treated as 1
//   i_count    in   NUM_W  number of pulses in the burst; 0 means no pulse
//   o_pulse    out  1      generated pulse line, driven directly from a flop
//   o_busy     out  1      high from the first active cycle through the last active cycle
//   o_done     out  1      one-cycle strobe when a burst completes normally
// BEHAVIOUR
//   Reset: state=IDLE; o_pulse=idle level; o_busy=0; o_done=0; counters=0.
//   Cycle notation: all transitions below require i_ena=1. With i_ena=0,
//     nothing changes, and o_done that is already high stays high.
//   FSM states: IDLE, ACTIVE, GAP.
//   IDLE
//     If i_start=1 and i_abort=0 and i_count!=0 at edge t:
//       - latch width, gap and count (using max(value,1) for width and gap)
//       - go to ACTIVE; from t+1, o_pulse=active and o_busy=1
//     If i_start=1 and i_count==0: stay in IDLE; o_done=1 for the single cycle t+1.
//     Otherwise: o_done=0.
//   ACTIVE
//     Hold for the latched width cycles.
//     Then, if more pulses remain: go to GAP with o_pulse=idle; o_busy stays 1.
//     If this was the last pulse: go to IDLE with o_pulse=idle, o_busy=0 and
//       o_done=1 in the same cycle, one cycle only.
//   GAP
//     Hold for the latched gap cycles, then go to ACTIVE for the next pulse.
//   Burst timing: total burst length = N*W + (N-1)*G cycles, where N, W and G
//     are the effective latched count, width and gap.
//   Latched values: input changes during a burst have no effect.
//   i_start in ACTIVE or GAP: ignored, not queued.
//   A new i_start is accepted in the cycle where o_done=1, because the FSM is
//     already in IDLE.
//   i_abort=1 in ACTIVE or GAP: next cycle state=IDLE, o_pulse=idle, o_busy=0,
//     o_done=0. A truncated pulse is allowed.
//   i_abort and i_start together in IDLE: abort wins, so no burst starts.
//   Counters: down-counters; no wrap-around is possible, since loads are >= 1.
//     Max width = 2^CNT_W-1 cycles; max pulses = 2^NUM_W-1.
//   Reset asserted mid-burst: o_pulse goes to the idle level immediately
//     (asynchronous); no o_done.
//   o_pulse is glitch-free: it comes only from a flop, with no combinational output path.
// TESTING
//   1 Reset: hold i_rst_n=0 mid-burst -> o_pulse=0 (HIGH) / 1 (LOW) at once;
//     o_busy=0, o_done=0.
//   2 width=3, gap=2, count=2, pulse at t -> o_pulse=1 on t+1..t+3 and t+6..t+8;
//     o_done=1 only at t+9; o_busy=1 on t+1..t+8.
//   3 width=0, gap=0, count=3 -> three 1-cycle pulses separated by 1 idle cycle;
//     bench edge detector counts 3 rising edges.
//   4 count=0 with start -> o_pulse never changes; o_done=1 for exactly one cycle;
//     o_busy stays 0.
//   5 Abort in 2nd cycle of width=5 pulse -> o_pulse idle next cycle; o_done stays 0;
//     start during burst ignored; start+abort in IDLE -> no burst.
//   6 i_ena toggled 0 for 4 cycles mid-pulse (width=4) -> active phase stretched
//     by exactly 4 cycles; POLARITY="LOW" run of test 2 -> inverted waveform.

Source files
------------

// File: rtl/pulse_generator_if.sv
// Control/status bundle for pulse_generator: burst request fields in, pulse line and status out.
// The master side drives the request; the slave side is the generator itself.
interface pulse_generator_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NUM_W = 8
) ();

    logic             i_ena;
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_width;
    logic [CNT_W-1:0] i_gap;
    logic [NUM_W-1:0] i_count;
    logic             o_pulse;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_ena,
        output i_start,
        output i_abort,
        output i_width,
        output i_gap,
        output i_count,
        input  o_pulse,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_ena,
        input  i_start,
        input  i_abort,
        input  i_width,
        input  i_gap,
        input  i_count,
        output o_pulse,
        output o_busy,
        output o_done
    );

endinterface

// File: rtl/pulse_generator.sv
// Burst pulse generator: N pulses of W active cycles separated by G idle cycles.
// All outputs come straight from flops, so the pulse line is glitch-free.
module pulse_generator #(
    parameter string       POLARITY = "HIGH",
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned NUM_W    = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    pulse_generator_if.slave  bus
);

    localparam logic IdleLvl = (POLARITY == "LOW") ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_evt;

    logic [CNT_W-1:0] width_eff;
    logic [CNT_W-1:0] gap_eff;
    logic             start_ok;
    logic             phase_last;
    logic             pulse_last;

    // Zero-length phases are promoted to one cycle so the down-counters never wrap.
    assign width_eff  = (bus.i_width == '0) ? CNT_W'(1) : bus.i_width;
    assign gap_eff    = (bus.i_gap == '0) ? CNT_W'(1) : bus.i_gap;
    assign start_ok   = bus.i_start & ~bus.i_abort;
    assign phase_last = (cnt_q == CNT_W'(1));
    assign pulse_last = (num_q == NUM_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            width_q <= '0;
            gap_q   <= '0;
            num_q   <= '0;
            pulse_q <= IdleLvl;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.i_ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            num_q   <= num_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        gap_d    = gap_q;
        num_d    = num_q;
        done_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    if (bus.i_count != '0) begin
                        width_d = width_eff;
                        gap_d   = gap_eff;
                        num_d   = bus.i_count;
                        cnt_d   = width_eff;
                        state_d = StActive;
                    end else begin
                        done_evt = 1'b1;
                    end
                end
            end
            StActive: begin
                if (bus.i_abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    num_d   = '0;
                end else if (phase_last) begin
                    if (pulse_last) begin
                        state_d  = StIdle;
                        cnt_d    = '0;
                        num_d    = '0;
                        done_evt = 1'b1;
                    end else begin
                        state_d = StGap;
                        cnt_d   = gap_q;
                        num_d   = num_q - NUM_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (bus.i_abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    num_d   = '0;
                end else if (phase_last) begin
                    state_d = StActive;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                num_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        pulse_d = (state_d == StActive) ? ~IdleLvl : IdleLvl;
        busy_d  = (state_d != StIdle);
        done_d  = done_evt;
    end

    assign bus.o_pulse = pulse_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: directed scenarios plus random bursts, checked against a
// timeline model built from the burst formula; HIGH and LOW polarity instances share stimulus.
module tb_pulse_generator;

    localparam int unsigned CW = 16;
    localparam int unsigned NW = 8;

    typedef struct packed {
        logic p;
        logic b;
        logic d;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pulse_generator_if #(.CNT_W(CW), .NUM_W(NW)) bus_h ();
    pulse_generator_if #(.CNT_W(CW), .NUM_W(NW)) bus_l ();

    assign bus_l.i_ena   = bus_h.i_ena;
    assign bus_l.i_start = bus_h.i_start;
    assign bus_l.i_abort = bus_h.i_abort;
    assign bus_l.i_width = bus_h.i_width;
    assign bus_l.i_gap   = bus_h.i_gap;
    assign bus_l.i_count = bus_h.i_count;

    pulse_generator #(.POLARITY("HIGH"), .CNT_W(CW), .NUM_W(NW)) dut_h (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_h)
    );

    pulse_generator #(.POLARITY("LOW"), .CNT_W(CW), .NUM_W(NW)) dut_l (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_l)
    );

    // Model: remaining per-cycle outputs of the current burst, and this cycle's outputs.
    out_t tl[$];
    out_t m;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   rises, high_n, busy_n, done_n, done_at;
    logic prev_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_burst(input int unsigned w, input int unsigned g, input int unsigned n);
        out_t e;
        int unsigned ww, gg;
        ww = (w == 0) ? 1 : w;
        gg = (g == 0) ? 1 : g;
        tl.delete();
        for (int k = 0; k < int'(n * ww + (n - 1) * gg); k++) begin
            e.p = ((k % (ww + gg)) < ww);
            e.b = 1'b1;
            e.d = 1'b0;
            tl.push_back(e);
        end
        e = '0;
        e.d = 1'b1;
        tl.push_back(e);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            tl.delete();
            m = '0;
            return;
        end
        if (!bus_h.i_ena) return;
        if (m.b) begin
            if (bus_h.i_abort) begin
                tl.delete();
                m = '0;
            end else begin
                m = tl.pop_front();
            end
        end else if (bus_h.i_start && !bus_h.i_abort && bus_h.i_count != '0) begin
            build_burst(int'(bus_h.i_width), int'(bus_h.i_gap), int'(bus_h.i_count));
            m = tl.pop_front();
        end else if (bus_h.i_start && !bus_h.i_abort) begin
            m = '0;
            m.d = 1'b1;
        end else begin
            m = '0;
        end
    endtask

    task automatic check_outputs();
        check("pulse_high", {31'd0, bus_h.o_pulse}, {31'd0, m.p});
        check("pulse_low",  {31'd0, bus_l.o_pulse}, {31'd0, ~m.p});
        check("busy_high",  {31'd0, bus_h.o_busy},  {31'd0, m.b});
        check("busy_low",   {31'd0, bus_l.o_busy},  {31'd0, m.b});
        check("done_high",  {31'd0, bus_h.o_done},  {31'd0, m.d});
        check("done_low",   {31'd0, bus_l.o_done},  {31'd0, m.d});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (bus_h.o_pulse && !prev_p) rises++;
        if (bus_h.o_pulse) high_n++;
        if (bus_h.o_busy) busy_n++;
        if (bus_h.o_done) done_n++;
        prev_p = bus_h.o_pulse;
    endtask

    task automatic clear_stats();
        rises  = 0;
        high_n = 0;
        busy_n = 0;
        done_n = 0;
    endtask

    task automatic set_req(input logic st, input logic ab, input int unsigned w,
                           input int unsigned g, input int unsigned c);
        bus_h.i_start = st;
        bus_h.i_abort = ab;
        bus_h.i_width = CW'(w);
        bus_h.i_gap   = CW'(g);
        bus_h.i_count = NW'(c);
    endtask

    initial begin
        m      = '0;
        prev_p = 1'b0;
        clear_stats();
        bus_h.i_ena = 1'b1;
        set_req(1'b0, 1'b0, 0, 0, 0);

        // Reset state
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Test 2: width 3, gap 2, count 2
        clear_stats();
        done_at = 0;
        set_req(1'b1, 1'b0, 3, 2, 2);
        for (int j = 1; j <= 11; j++) begin
            step();
            if (j == 1) bus_h.i_start = 1'b0;
            if (bus_h.o_done) done_at = j;
        end
        check("t2_done_at", done_at, 9);
        check("t2_busy_cycles", busy_n, 8);
        check("t2_high_cycles", high_n, 6);

        // Test 3: zero width and gap behave as 1
        clear_stats();
        set_req(1'b1, 1'b0, 0, 0, 3);
        step();
        bus_h.i_start = 1'b0;
        for (int j = 0; j < 8; j++) step();
        check("t3_rising_edges", rises, 3);
        check("t3_done_count", done_n, 1);

        // Test 4: count 0
        clear_stats();
        set_req(1'b1, 1'b0, 4, 4, 0);
        step();
        bus_h.i_start = 1'b0;
        for (int j = 0; j < 4; j++) step();
        check("t4_done_count", done_n, 1);
        check("t4_busy_cycles", busy_n, 0);
        check("t4_high_cycles", high_n, 0);

        // Test 5: abort in second active cycle, start ignored mid-burst, start+abort idle
        clear_stats();
        set_req(1'b1, 1'b0, 5, 1, 2);
        step();
        step();
        set_req(1'b0, 1'b1, 5, 1, 2);
        step();
        bus_h.i_abort = 1'b0;
        for (int j = 0; j < 3; j++) step();
        set_req(1'b1, 1'b1, 2, 2, 2);
        step();
        set_req(1'b0, 1'b0, 2, 2, 2);
        for (int j = 0; j < 4; j++) step();
        check("t5_done_count", done_n, 0);
        check("t5_high_cycles", high_n, 2);

        // Test 6: enable low for 4 cycles mid-pulse
        clear_stats();
        set_req(1'b1, 1'b0, 4, 1, 1);
        step();
        bus_h.i_start = 1'b0;
        step();
        bus_h.i_ena = 1'b0;
        for (int j = 0; j < 4; j++) step();
        bus_h.i_ena = 1'b1;
        for (int j = 0; j < 6; j++) step();
        check("t6_high_cycles", high_n, 8);
        check("t6_done_count", done_n, 1);

        // Test 1: asynchronous reset mid-burst
        set_req(1'b1, 1'b0, 6, 2, 3);
        step();
        bus_h.i_start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        tl.delete();
        m = '0;
        check_outputs();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Random bursts with enable gaps, mid-burst input churn, stray starts and aborts
        for (int i = 0; i < 700; i++) begin
            bus_h.i_ena = ($urandom_range(0, 5) != 0);
            if (!m.b) begin
                bus_h.i_start = ($urandom_range(0, 3) == 0);
                bus_h.i_abort = bus_h.i_start ? 1'b0 : ($urandom_range(0, 9) == 0);
                bus_h.i_width = CW'($urandom_range(0, 4));
                bus_h.i_gap   = CW'($urandom_range(0, 3));
                bus_h.i_count = NW'($urandom_range(0, 4));
            end else begin
                bus_h.i_start = ($urandom_range(0, 7) == 0);
                bus_h.i_abort = ($urandom_range(0, 39) == 0);
                bus_h.i_width = CW'($urandom_range(0, 7));
                bus_h.i_gap   = CW'($urandom_range(0, 7));
                bus_h.i_count = NW'($urandom_range(0, 7));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
